psum_accumulator: RTL and testbench

- Downstream stage of the saturating 16Q11 adder in the conv datapath. Consumes its stream of partial sums for one output pixel.
- Accumulates a fixed number of terms at extended precision, then adds the channel bias.
- Saturates the total once to 16Q11 and optionally applies ReLU.
- Emits one result per output pixel over a valid/ready handshake toward the pooling stage.

---
 rtl/psum_accumulator.sv | 135 +++++++++++++
 tb/tb_psum_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums NUM_TERMS 16Q11 terms plus bias at
// extended precision, saturates once, optional ReLU, valid/ready output.
module psum_accumulator #(
  parameter int dwidth    = 16,
  parameter int awidth    = 24,
  parameter int NUM_TERMS = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [dwidth-1:0] bias,
  input  logic              relu_en,
  output logic              busy,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [dwidth-1:0] din,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [dwidth-1:0] dout
);

  localparam int CW = 8;
  localparam int XW = awidth - dwidth;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    BIAS,
    SAT,
    OUT
  } state_t;

  state_t            state_q;
  logic [awidth-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic [dwidth-1:0] bias_q;
  logic              relu_q;
  logic              din_ready_q;
  logic              dout_valid_q;
  logic [dwidth-1:0] dout_q;

  logic [awidth-1:0] din_ext_d;
  logic [awidth-1:0] bias_ext_d;
  logic [XW:0]       top_d;
  logic              fits_d;
  logic [dwidth-1:0] sat_d;
  logic [dwidth-1:0] res_d;
  logic              take_d;
  logic              last_d;

  assign din_ext_d  = {{XW{din[dwidth-1]}}, din};
  assign bias_ext_d = {{XW{bias_q[dwidth-1]}}, bias_q};

  // Value fits 16 bits when every bit above the result sign matches it
  assign top_d  = acc_q[awidth-1:dwidth-1];
  assign fits_d = (&top_d) | ~(|top_d);

  always_comb begin
    sat_d = acc_q[dwidth-1:0];
    if (!fits_d) begin
      if (acc_q[awidth-1]) begin
        sat_d = {1'b1, {(dwidth-1){1'b0}}};
      end else begin
        sat_d = {1'b0, {(dwidth-1){1'b1}}};
      end
    end
  end

  assign res_d  = (relu_q && sat_d[dwidth-1]) ? '0 : sat_d;
  assign take_d = din_valid & din_ready_q;
  assign last_d = (cnt_q == CW'(NUM_TERMS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      bias_q       <= '0;
      relu_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          din_ready_q <= 1'b0;
          if (start) begin
            bias_q      <= bias;
            relu_q      <= relu_en;
            acc_q       <= '0;
            cnt_q       <= '0;
            din_ready_q <= 1'b1;
            state_q     <= ACC;
          end
        end
        ACC: begin
          if (take_d) begin
            acc_q <= acc_q + din_ext_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_d) begin
              din_ready_q <= 1'b0;
              state_q     <= BIAS;
            end
          end
        end
        BIAS: begin
          acc_q   <= acc_q + bias_ext_d;
          state_q <= SAT;
        end
        SAT: begin
          dout_q       <= res_d;
          dout_valid_q <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          din_ready_q  <= 1'b0;
          dout_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed and random pixels against an
// integer reference (sum, clamp, ReLU).
module tb_psum_accumulator;

  localparam int NT = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        relu_en;
  logic        busy;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;

  logic [15:0] tq [256];
  int          tn;

  psum_accumulator #(
    .dwidth(16),
    .awidth(24),
    .NUM_TERMS(NT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bias(bias),
    .relu_en(relu_en),
    .busy(busy),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .din(din),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] b,
                                        input logic r);
    longint s;
    s = longint'($signed(b));
    for (int i = 0; i < tn; i++) s += longint'($signed(tq[i]));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (r && s < 0) s = 0;
    return s[15:0];
  endfunction

  task automatic fill(input logic [15:0] v);
    tn = NT;
    for (int i = 0; i < NT; i++) tq[i] = v;
  endtask

  task automatic run_pixel(input logic [15:0] b, input logic r,
                           input int gap, input int bp,
                           input bit sio);
    logic [15:0] exp;
    int idx;
    int cyc;
    exp = model(b, r);
    dout_ready = (bp == 0);
    chk("idle_din_ready", din_ready, 0);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    bias = b;
    relu_en = r;
    @(negedge clk);
    start = 1'b0;
    bias = 16'($urandom);
    relu_en = 1'($urandom);
    chk("acc_busy", busy, 1);
    chk("acc_din_ready", din_ready, 1);
    idx = 0;
    cyc = 0;
    while (idx < tn && cyc < 2000) begin
      din_valid = ($urandom_range(99) >= gap);
      din = din_valid ? tq[idx] : 16'($urandom);
      if (din_valid && din_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("accept_timeout", cyc, 0);
    din_valid = 1'b1;
    din = 16'h1234;
    chk("bias_din_ready", din_ready, 0);
    chk("bias_dout_valid", dout_valid, 0);
    @(negedge clk);
    chk("sat_din_ready", din_ready, 0);
    chk("sat_dout_valid", dout_valid, 0);
    @(negedge clk);
    din_valid = 1'b0;
    chk("out_dout_valid", dout_valid, 1);
    chk("out_dout", dout, exp);
    for (int k = 0; k < bp; k++) begin
      start = sio && (k == 0);
      @(negedge clk);
      start = 1'b0;
      chk("hold_dout_valid", dout_valid, 1);
      chk("hold_dout", dout, exp);
      chk("hold_din_ready", din_ready, 0);
    end
    dout_ready = 1'b1;
    start = sio;
    @(negedge clk);
    start = 1'b0;
    chk("done_dout_valid", dout_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_dout_kept", dout, exp);
    chk("done_din_ready", din_ready, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bias = '0;
    relu_en = 1'b0;
    din_valid = 1'b0;
    din = '0;
    dout_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    fill(16'h0080);
    run_pixel(16'h0400, 1'b0, 0, 0, 1'b0);
    fill(16'h0800);
    run_pixel(16'h0000, 1'b0, 0, 0, 1'b0);
    fill(16'hF800);
    run_pixel(16'h0000, 1'b0, 0, 0, 1'b0);
    run_pixel(16'h0000, 1'b1, 0, 0, 1'b0);

    tn = NT;
    for (int i = 0; i < 12; i++) tq[i] = 16'h7FFF;
    for (int i = 12; i < 24; i++) tq[i] = 16'h8001;
    tq[24] = 16'h0100;
    run_pixel(16'h0000, 1'b0, 0, 0, 1'b0);

    fill(16'h0123);
    run_pixel(16'hFF00, 1'b0, 40, 5, 1'b1);

    fill(16'h0200);
    start = 1'b1;
    bias = 16'h1000;
    @(negedge clk);
    start = 1'b0;
    din_valid = 1'b1;
    din = 16'h0200;
    for (int i = 0; i < 10; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_din_ready", din_ready, 0);
    chk("mid_rst_dout_valid", dout_valid, 0);
    chk("mid_rst_dout", dout, 0);
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(16'h0080);
    run_pixel(16'h0000, 1'b0, 0, 0, 1'b0);

    for (int p = 0; p < 8; p++) begin
      tn = NT;
      for (int i = 0; i < NT; i++) begin
        if (p[0]) tq[i] = 16'($urandom);
        else tq[i] = 16'($urandom_range(4095)) - 16'd2048;
      end
      run_pixel(16'($urandom), 1'($urandom), 30,
                $urandom_range(3), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
